// File: rtl/slap_spr_pkg.sv
// Shared types and defaults for the sprite line-buffer engine.
package slap_spr_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR
    } spr_state_t;

    localparam int DEF_H_BITS        = 9;
    localparam int DEF_LINE_LEN      = 384;
    localparam int DEF_TILE_W        = 8;
    localparam int DEF_BPP           = 4;
    localparam int DEF_COL_W         = 4;
    localparam int DEF_PRIO_FIRST    = 1;
    localparam int DEF_CLEAR_ON_READ = 1;

    // pix_out carries {colour, pixel}
    function automatic int pix_w(input int bpp, input int col_w);
        return bpp + col_w;
    endfunction

endpackage

// File: rtl/spr_lb_bank.sv
// Single-port line-buffer bank: synchronous write, one-cycle registered read.
module spr_lb_bank
    import slap_spr_pkg::*;
#(
    parameter int AW = DEF_H_BITS,
    parameter int DW = pix_w(DEF_BPP, DEF_COL_W)
) (
    input  logic          clk,
    input  logic [AW-1:0] i_addr,
    input  logic          i_we,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [2**AW];

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_addr] <= i_wdata;
        o_rdata <= r_mem[i_addr];
    end

endmodule

// File: rtl/sprite_linebuf_engine.sv
// Double-banked sprite line buffer: draw engine fills one bank while the
// display side reads (and optionally clears) the other.
module sprite_linebuf_engine
    import slap_spr_pkg::*;
#(
    parameter int H_BITS        = DEF_H_BITS,
    parameter int LINE_LEN      = DEF_LINE_LEN,
    parameter int TILE_W        = DEF_TILE_W,
    parameter int BPP           = DEF_BPP,
    parameter int COL_W         = DEF_COL_W,
    parameter int PRIO_FIRST    = DEF_PRIO_FIRST,
    parameter int CLEAR_ON_READ = DEF_CLEAR_ON_READ
) (
    input  logic                          master_clk,
    input  logic                          nRESET,
    input  logic                          line_sync,
    input  logic                          pix_ce,
    input  logic [H_BITS-1:0]             rd_x,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [H_BITS-1:0]             cmd_x,
    input  logic [TILE_W*BPP-1:0]         cmd_gfx,
    input  logic [COL_W-1:0]              cmd_col,
    input  logic                          cmd_flip,
    output logic [pix_w(BPP,COL_W)-1:0]   pix_out,
    output logic                          overrun
);

    localparam int PW = pix_w(BPP, COL_W);
    localparam int IW = (TILE_W > 1) ? $clog2(TILE_W) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(TILE_W - 1);

    spr_state_t r_state, w_next;

    logic                  r_disp_bank, r_rst_done, r_overrun, r_ce_d1, r_rd_bank;
    logic [1:0]            r_sync_cnt;
    logic [H_BITS-1:0]     r_x, r_rd_addr;
    logic [TILE_W*BPP-1:0] r_gfx;
    logic [COL_W-1:0]      r_col;
    logic                  r_flip;
    logic [IW-1:0]         r_idx;
    logic [PW-1:0]         r_pix_out;

    logic                  w_accept, w_busy, w_draw_we, w_wb;
    logic [IW-1:0]         w_fld;
    logic [BPP-1:0]        w_pix;
    logic [H_BITS-1:0]     w_draw_addr;
    logic [H_BITS-1:0]     w_addr  [2];
    logic                  w_we    [2];
    logic [PW-1:0]         w_wdata [2];
    logic [PW-1:0]         w_rdata [2];

    assign cmd_ready   = r_rst_done && (r_state == S_IDLE);
    assign w_accept    = cmd_valid && cmd_ready;
    assign w_busy      = (r_state != S_IDLE);
    assign w_wb        = ~r_disp_bank;
    assign w_fld       = r_flip ? (LAST_IDX - r_idx) : r_idx;
    assign w_pix       = r_gfx[w_fld*BPP +: BPP];
    assign w_draw_addr = r_x + H_BITS'(r_idx);

    always_ff @(posedge master_clk) begin
        if (!nRESET)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // RD fetches the stored entry so WR can apply the priority rule.
    always_comb begin
        w_next    = r_state;
        w_draw_we = 1'b0;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_RD;
            S_RD:   w_next = line_sync ? S_IDLE : S_WR;
            S_WR: begin
                if (line_sync) begin
                    w_next = S_IDLE;
                end else begin
                    w_draw_we = (w_pix != '0) && (32'(w_draw_addr) < LINE_LEN) &&
                                !((PRIO_FIRST != 0) && (w_rdata[w_wb][BPP-1:0] != '0));
                    w_next = (r_idx == LAST_IDX) ? S_IDLE : S_RD;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge master_clk) begin
        if (w_accept) begin
            r_x    <= cmd_x;
            r_gfx  <= cmd_gfx;
            r_col  <= cmd_col;
            r_flip <= cmd_flip;
            r_idx  <= '0;
        end else if (r_state == S_WR) begin
            r_idx  <= r_idx + 1'b1;
        end
    end

    always_ff @(posedge master_clk) begin
        if (!nRESET) begin
            r_disp_bank <= 1'b0;
            r_sync_cnt  <= '0;
            r_overrun   <= 1'b0;
            r_rst_done  <= 1'b0;
            r_ce_d1     <= 1'b0;
            r_pix_out   <= '0;
        end else begin
            r_rst_done <= 1'b1;
            r_overrun  <= line_sync && w_busy;
            r_ce_d1    <= pix_ce;
            if (line_sync) begin
                r_disp_bank <= ~r_disp_bank;
                if (r_sync_cnt != 2'd2)
                    r_sync_cnt <= r_sync_cnt + 2'd1;
            end
            if (r_ce_d1)
                r_pix_out <= (r_sync_cnt == 2'd2) ? w_rdata[r_rd_bank] : '0;
        end
    end

    always_ff @(posedge master_clk) begin
        if (pix_ce) begin
            r_rd_addr <= rd_x;
            r_rd_bank <= r_disp_bank;
        end
    end

    // The clear write reuses the display port in the cycle after the read.
    always_comb begin
        for (int unsigned b = 0; b < 2; b++) begin
            if (1'(b) == r_disp_bank) begin
                w_addr[b]  = pix_ce ? rd_x : r_rd_addr;
                w_we[b]    = (CLEAR_ON_READ != 0) && r_ce_d1 && nRESET;
                w_wdata[b] = '0;
            end else begin
                w_addr[b]  = w_draw_addr;
                w_we[b]    = w_draw_we && nRESET;
                w_wdata[b] = {r_col, w_pix};
            end
        end
    end

    spr_lb_bank #(.AW(H_BITS), .DW(PW)) u_bank0 (
        .clk(master_clk), .i_addr(w_addr[0]), .i_we(w_we[0]),
        .i_wdata(w_wdata[0]), .o_rdata(w_rdata[0])
    );

    spr_lb_bank #(.AW(H_BITS), .DW(PW)) u_bank1 (
        .clk(master_clk), .i_addr(w_addr[1]), .i_we(w_we[1]),
        .i_wdata(w_wdata[1]), .o_rdata(w_rdata[1])
    );

    assign pix_out = r_pix_out;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_sprite_linebuf_engine.sv
// Randomised bench for sprite_linebuf_engine against a per-bank array model,
// run on a first-wins and a last-wins instance sharing the same stimulus.
module tb_sprite_linebuf_engine;

    localparam int HB = 9;
    localparam int LL = 384;
    localparam int TW = 8;
    localparam int NA = 512;

    logic          clk = 1'b0;
    logic          nRESET, line_sync, pix_ce, cmd_valid, cmd_flip;
    logic [HB-1:0] rd_x, cmd_x;
    logic [31:0]   cmd_gfx;
    logic [3:0]    cmd_col;
    logic          cmd_ready, overrun, cmd_ready_l, overrun_l;
    logic [7:0]    pix_out, pix_out_l;

    always #5 clk = ~clk;

    sprite_linebuf_engine #(.PRIO_FIRST(1)) u_dut_f (
        .master_clk(clk), .nRESET(nRESET), .line_sync(line_sync), .pix_ce(pix_ce),
        .rd_x(rd_x), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_x(cmd_x),
        .cmd_gfx(cmd_gfx), .cmd_col(cmd_col), .cmd_flip(cmd_flip),
        .pix_out(pix_out), .overrun(overrun)
    );

    sprite_linebuf_engine #(.PRIO_FIRST(0)) u_dut_l (
        .master_clk(clk), .nRESET(nRESET), .line_sync(line_sync), .pix_ce(pix_ce),
        .rd_x(rd_x), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_l), .cmd_x(cmd_x),
        .cmd_gfx(cmd_gfx), .cmd_col(cmd_col), .cmd_flip(cmd_flip),
        .pix_out(pix_out_l), .overrun(overrun_l)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mf [2][NA];
    logic [7:0] ml [2][NA];
    int m_disp  = 0;
    int m_syncs = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Draws npix pixels of a tile into the model's write bank.
    function automatic void m_draw(input int x, input logic [31:0] gfx, input logic [3:0] col,
                                   input logic flip, input int npix);
        int wb;
        int a;
        int f;
        logic [3:0] p;
        wb = 1 - m_disp;
        for (int i = 0; i < npix; i++) begin
            a = (x + i) % NA;
            f = flip ? (TW - 1 - i) : i;
            p = 4'((gfx >> (4 * f)) & 32'hF);
            if (p != 4'h0 && a < LL) begin
                if (mf[wb][a][3:0] == 4'h0) mf[wb][a] = {col, p};
                ml[wb][a] = {col, p};
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_sync();
        line_sync = 1'b1;
        tick();
        line_sync = 1'b0;
        m_disp = 1 - m_disp;
        if (m_syncs < 2) m_syncs++;
        chk("overrun_idle", 32'(overrun), 32'd0);
    endtask

    task automatic rd(input int x);
        logic [7:0] ef;
        logic [7:0] el;
        rd_x   = HB'(x);
        pix_ce = 1'b1;
        tick();
        pix_ce = 1'b0;
        tick();
        ef = (m_syncs >= 2) ? mf[m_disp][x] : 8'h00;
        el = (m_syncs >= 2) ? ml[m_disp][x] : 8'h00;
        chk($sformatf("pix_first[%0d]", x), 32'(pix_out), 32'(ef));
        chk($sformatf("pix_last[%0d]", x), 32'(pix_out_l), 32'(el));
        mf[m_disp][x] = 8'h00;
        ml[m_disp][x] = 8'h00;
    endtask

    task automatic do_cmd(input int x, input logic [31:0] gfx, input logic [3:0] col, input logic flip);
        int n;
        cmd_x = HB'(x); cmd_gfx = gfx; cmd_col = col; cmd_flip = flip; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        chk("ready_wait", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        chk("ready_busy", 32'(cmd_ready), 32'd0);
        n = 0;
        while (!cmd_ready && n < 100) begin tick(); n++; end
        chk("ready_latency", 32'(n), 32'(2 * TW));
        m_draw(x, gfx, col, flip, TW);
    endtask

    task automatic rd_span(input int x, input int len);
        for (int i = 0; i < len; i++) rd((x + i) % NA);
    endtask

    initial begin
        int xs [3];
        int nc;
        int b;
        logic [7:0] held;
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < NA; a++) begin mf[k][a] = 8'h00; ml[k][a] = 8'h00; end

        nRESET = 1'b0; line_sync = 1'b0; pix_ce = 1'b0; rd_x = '0;
        cmd_valid = 1'b0; cmd_x = '0; cmd_gfx = '0; cmd_col = '0; cmd_flip = 1'b0;
        repeat (3) tick();
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        chk("rst_ready_l", 32'(cmd_ready_l), 32'd0);
        chk("rst_pix", 32'(pix_out), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        nRESET = 1'b1;
        tick();
        chk("ready_after_rst", 32'(cmd_ready), 32'd1);

        // Data drawn before the second line_sync must still read as zero.
        do_cmd(100, 32'h11111111, 4'd1, 1'b0);
        rd_span(0, NA);
        do_sync();
        rd_span(0, NA);
        do_sync();

        do_cmd(10, 32'h87654321, 4'd5, 1'b0);
        do_sync();
        rd_span(10, 9);
        chk("basic_x10", 32'(pix_out), 32'h00);
        rd(11);
        held = pix_out;
        repeat (4) tick();
        chk("pix_hold", 32'(pix_out), 32'(held));

        do_cmd(10, 32'h87654321, 4'd5, 1'b1);
        do_sync();
        rd(10);
        chk("flip_x10", 32'(pix_out), 32'h58);
        rd_span(11, 7);
        chk("flip_x17", 32'(pix_out), 32'h51);

        do_cmd(10, 32'h87650321, 4'd5, 1'b0);
        do_sync();
        rd_span(10, 8);

        do_cmd(20, 32'h22222222, 4'd1, 1'b0);
        do_cmd(24, 32'hFFFFFFFF, 4'd3, 1'b0);
        do_sync();
        rd_span(20, 12);

        do_cmd(380, 32'h11111111, 4'd2, 1'b0);
        do_sync();
        rd_span(380, 8);
        rd(0);
        do_cmd(508, 32'h23456789, 4'd6, 1'b0);
        do_sync();
        rd_span(508, 9);

        // Abort: line_sync lands on RD of pixel 2.
        cmd_x = HB'(40); cmd_gfx = 32'h99999999; cmd_col = 4'd7; cmd_flip = 1'b0; cmd_valid = 1'b1;
        chk("abort_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        repeat (4) tick();
        line_sync = 1'b1;
        tick();
        line_sync = 1'b0;
        m_draw(40, 32'h99999999, 4'd7, 1'b0, 2);
        m_disp = 1 - m_disp;
        chk("abort_overrun", 32'(overrun), 32'd1);
        chk("abort_overrun_l", 32'(overrun_l), 32'd1);
        chk("abort_ready_next", 32'(cmd_ready), 32'd1);
        tick();
        chk("abort_overrun_end", 32'(overrun), 32'd0);
        rd_span(40, 8);
        do_sync();
        do_sync();
        rd(40);

        for (int r = 0; r < 12; r++) begin
            nc = int'($urandom_range(1, 3));
            for (int c = 0; c < nc; c++) begin
                xs[c] = int'($urandom_range(0, NA - 1));
                do_cmd(xs[c], $urandom, 4'($urandom), 1'($urandom));
            end
            do_sync();
            for (int c = 0; c < nc; c++) rd_span(xs[c], TW);
            for (int k = 0; k < 4; k++) rd(int'($urandom_range(0, NA - 1)));
        end

        // Reset in RD of pixel 1: only pixel 0 may land in the bank.
        cmd_x = HB'(60); cmd_gfx = 32'h55555555; cmd_col = 4'd4; cmd_flip = 1'b0; cmd_valid = 1'b1;
        chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        m_draw(60, 32'h55555555, 4'd4, 1'b0, 1);
        b = 1 - m_disp;
        nRESET = 1'b0;
        tick();
        chk("mid_rst_overrun", 32'(overrun), 32'd0);
        chk("mid_rst_ready_lo", 32'(cmd_ready), 32'd0);
        chk("mid_rst_pix", 32'(pix_out), 32'd0);
        tick();
        nRESET = 1'b1;
        m_disp = 0;
        m_syncs = 0;
        tick();
        chk("mid_rst_ready_hi", 32'(cmd_ready), 32'd1);
        chk("mid_rst_overrun2", 32'(overrun), 32'd0);
        for (int k = 0; k < 4 && !(m_syncs >= 2 && m_disp == b); k++) do_sync();
        rd_span(60, 8);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
